smpl_txfifo: RTL and testbench

//  Transmit-direction sample FIFO for audio playback: the bus side writes
//  BW-bit samples at will, and a downstream DAC/PWM driver drains exactly one

---
 rtl/smpl_txfifo.sv | 99 +++++++++
 tb/tb_smpl_txfifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/smpl_txfifo.sv
// Playback sample FIFO: the bus writes samples freely, and the output driver
// drains one sample per sample-rate strobe. Overflow and underflow are sticky.
module smpl_txfifo #(
   parameter int BW     = 12,
   parameter int LGFLEN = 9
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_wr,
   input  logic [BW-1:0] i_data,
   input  logic          i_stb,
   input  logic          i_clr_err,
   output logic [BW-1:0] o_data,
   output logic          o_valid,
   output logic          o_empty_n,
   output logic [15:0]   o_status,
   output logic [1:0]    o_err
);

   localparam int DEPTH = 1 << LGFLEN;

   logic [BW-1:0]     mem [DEPTH];
   logic [LGFLEN-1:0] wptr_q, wptr_d;
   logic [LGFLEN-1:0] rptr_q, rptr_d;
   logic [BW-1:0]     data_q, data_d;
   logic              valid_q, valid_d;
   logic [1:0]        err_q, err_d;

   logic [LGFLEN-1:0] fill;
   logic [LGFLEN-1:0] free;
   logic              not_empty;
   logic              full_n;
   logic              rd_ok;
   logic              wr_ok;

   // One slot is kept unused, so (DEPTH-1)-fill is simply the inverse of fill.
   assign fill      = wptr_q - rptr_q;
   assign free      = ~fill;
   assign not_empty = (fill != '0);
   assign full_n    = (fill != '1);

   // A strobe frees a slot this cycle, so a write to a full FIFO still lands.
   assign rd_ok = i_stb && not_empty;
   assign wr_ok = i_wr && (full_n || rd_ok);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no latch is inferred.
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      data_d  = data_q;
      valid_d = 1'b0;
      err_d   = i_clr_err ? 2'b00 : err_q;

      if (wr_ok) begin
         wptr_d = wptr_q + LGFLEN'(1);
      end else if (i_wr) begin
         err_d[1] = 1'b1;
      end

      if (rd_ok) begin
         rptr_d  = rptr_q + LGFLEN'(1);
         data_d  = mem[rptr_q];
         valid_d = 1'b1;
      end else if (i_stb) begin
         err_d[0] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 2'b00;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   // NOTE: storage has no reset; the cleared pointers make stale contents unreachable.
   always_ff @(posedge i_clk) begin
      if (wr_ok) begin
         mem[wptr_q] <= i_data;
      end
   end

   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_err     = err_q;
   assign o_empty_n = not_empty;
   assign o_status  = {14'(free), free[LGFLEN-1], full_n};

endmodule

// File: tb/tb_smpl_txfifo.sv
// Directed bench for smpl_txfifo: ordering, underflow, overflow, full with
// simultaneous strobe, and asynchronous reset with samples queued.
module tb_smpl_txfifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr = 1'b0;
   logic [11:0] din = '0;
   logic        stb = 1'b0;
   logic        clr = 1'b0;
   logic [11:0] dout;
   logic        valid;
   logic        empty_n;
   logic [15:0] status;
   logic [1:0]  err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   smpl_txfifo #(.BW(12), .LGFLEN(9)) dut (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_wr     (wr),
      .i_data   (din),
      .i_stb    (stb),
      .i_clr_err(clr),
      .o_data   (dout),
      .o_valid  (valid),
      .o_empty_n(empty_n),
      .o_status (status),
      .o_err    (err)
   );

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (status !== 16'h07FF) begin errors++; $display("FAIL reset_status: got %h want 07ff", status); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err: got %b want 00", err); end
      checks++; if (dout !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", dout); end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL reset_empty_n: got %b want 0", empty_n); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
   endtask

   task automatic test_order();
      logic [11:0] vals [3] = '{12'h123, 12'h456, 12'h789};
      int pulses = 0;
      for (int i = 0; i < 3; i++) begin
         wr = 1'b1; din = vals[i];
         tick();
      end
      wr = 1'b0;
      tick();
      checks++; if (status !== 16'h07F3) begin errors++; $display("FAIL order_status3: got %h want 07f3", status); end
      checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL order_empty_n: got %b want 1", empty_n); end
      for (int i = 0; i < 3; i++) begin
         stb = 1'b1;
         tick();
         stb = 1'b0;
         if (valid === 1'b1) pulses++;
         checks++; if (dout !== vals[i]) begin errors++; $display("FAIL order_data%0d: got %h want %h", i, dout, vals[i]); end
         tick();
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL order_valid_drop%0d: got %b want 0", i, valid); end
         checks++; if (dout !== vals[i]) begin errors++; $display("FAIL order_hold%0d: got %h want %h", i, dout, vals[i]); end
         tick();
      end
      checks++; if (pulses !== 3) begin errors++; $display("FAIL order_pulses: got %0d want 3", pulses); end
      checks++; if (empty_n !== 1'b0) begin errors++; $display("FAIL order_empty_end: got %b want 0", empty_n); end
      checks++; if (status !== 16'h07FF) begin errors++; $display("FAIL order_status_end: got %h want 07ff", status); end
   endtask

   task automatic test_underflow();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      checks++; if (dout !== 12'h789) begin errors++; $display("FAIL uf_hold: got %h want 789", dout); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL uf_valid: got %b want 0", valid); end
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL uf_err: got %b want 01", err); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL uf_clear: got %b want 00", err); end
      // Clear and a new underflow in the same cycle: the event wins.
      clr = 1'b1; stb = 1'b1;
      tick();
      clr = 1'b0; stb = 1'b0;
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL uf_clr_race: got %b want 01", err); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      // Write plus strobe on empty: sample stored, strobe still underflows.
      wr = 1'b1; din = 12'h5A5; stb = 1'b1;
      tick();
      wr = 1'b0; stb = 1'b0;
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL nobypass_err: got %b want 01", err); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL nobypass_valid: got %b want 0", valid); end
      checks++; if (empty_n !== 1'b1) begin errors++; $display("FAIL nobypass_empty_n: got %b want 1", empty_n); end
      stb = 1'b1;
      tick();
      stb = 1'b0;
      checks++; if (dout !== 12'h5A5) begin errors++; $display("FAIL nobypass_data: got %h want 5a5", dout); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 512; i++) begin
         wr = 1'b1; din = 12'(i);
         tick();
         if (i == 510) begin
            checks++; if (err !== 2'b00) begin errors++; $display("FAIL ovf_err_at_full: got %b want 00", err); end
            checks++; if (status !== 16'h0000) begin errors++; $display("FAIL ovf_status_at_full: got %h want 0000", status); end
         end
      end
      wr = 1'b0;
      checks++; if (err !== 2'b10) begin errors++; $display("FAIL ovf_err: got %b want 10", err); end
      checks++; if (status !== 16'h0000) begin errors++; $display("FAIL ovf_status: got %h want 0000", status); end
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_full_simul();
      wr = 1'b1; din = 12'hABC; stb = 1'b1;
      tick();
      wr = 1'b0;
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL simul_err: got %b want 00", err); end
      checks++; if (status !== 16'h0000) begin errors++; $display("FAIL simul_status: got %h want 0000", status); end
      checks++; if (dout !== 12'h000 || valid !== 1'b1) begin errors++; $display("FAIL simul_read: got %h/%b want 000/1", dout, valid); end
      for (int i = 1; i <= 511; i++) begin
         logic [11:0] exp;
         exp = (i == 511) ? 12'hABC : 12'(i);
         tick();
         checks++; if (dout !== exp || valid !== 1'b1) begin errors++; $display("FAIL drain%0d: got %h/%b want %h/1", i, dout, valid, exp); end
      end
      stb = 1'b0;
      checks++; if (status !== 16'h07FF) begin errors++; $display("FAIL drain_status: got %h want 07ff", status); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL drain_err: got %b want 00", err); end
      tick();
   endtask

   task automatic test_reset_mid();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         wr = 1'b1; din = 12'h300 + 12'(i);
         tick();
      end
      wr = 1'b0;
      stb = 1'b1;
      tick();
      stb = 1'b0;
      checks++; if (status !== 16'h07EB || dout !== 12'h300 || err !== 2'b01) begin errors++; $display("FAIL pre_reset: got %h/%h/%b want 07eb/300/01", status, dout, err); end
      rst = 1'b1;
      #2;
      checks++; if (dout !== 12'h000 || valid !== 1'b0) begin errors++; $display("FAIL async_rst_data: got %h/%b want 000/0", dout, valid); end
      checks++; if (status !== 16'h07FF || empty_n !== 1'b0) begin errors++; $display("FAIL async_rst_status: got %h/%b want 07ff/0", status, empty_n); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL async_rst_err: got %b want 00", err); end
      tick();
      rst = 1'b0;
      tick();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      checks++; if (err !== 2'b01) begin errors++; $display("FAIL post_rst_err: got %b want 01", err); end
      checks++; if (dout !== 12'h000 || valid !== 1'b0) begin errors++; $display("FAIL post_rst_data: got %h/%b want 000/0", dout, valid); end
   endtask

   initial begin
      test_reset();
      test_order();
      test_underflow();
      test_overflow();
      test_full_simul();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
